// File: rtl/hier_path_decoder.sv
// hier_path_decoder: rebuilds a serial child-index digit stream into a packed level-indexed path.
module hier_path_decoder #(
    parameter int LEVELS  = 10,
    parameter int FANOUT  = 5,
    parameter int DIGIT_W = 3,
    parameter int DEPTH_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W-1:0]        in_digit,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LEVELS*DIGIT_W-1:0] out_path,
    output logic [DEPTH_W-1:0]        out_depth,
    output logic                      out_err
);
    typedef enum logic {COLLECT, HOLD} state_t;
    state_t state, state_d;
    logic [DEPTH_W-1:0]        cnt, cnt_d;
    logic [LEVELS*DIGIT_W-1:0] path, path_d;
    logic                      err, err_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            cnt   <= '0;
            path  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            path  <= path_d;
            err   <= err_d;
        end
    end
    // Overflow beats still count as accepted so the source never stalls on a malformed path.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        path_d  = path;
        err_d   = err;
        if (state == COLLECT) begin
            if (in_valid) begin
                if (cnt < DEPTH_W'(LEVELS)) begin
                    for (int k = 0; k < LEVELS; k++)
                        if (cnt == DEPTH_W'(k)) path_d[k*DIGIT_W +: DIGIT_W] = in_digit;
                    cnt_d = cnt + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                if ({1'b0, in_digit} >= (DIGIT_W+1)'(FANOUT)) err_d = 1'b1;
                if (in_last) state_d = HOLD;
            end
        end else if (out_ready) begin
            state_d = COLLECT;
            cnt_d   = '0;
            path_d  = '0;
            err_d   = 1'b0;
        end
    end
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign out_path  = path;
    assign out_depth = cnt;
    assign out_err   = err;
endmodule

// File: tb/tb_hier_path_decoder.sv
// tb_hier_path_decoder: table-driven directed checks of path rebuild, overflow, stall and reset.
module tb_hier_path_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_err;
    logic [2:0]  in_digit;
    logic [29:0] out_path;
    logic [3:0]  out_depth;
    int          errors = 0;
    int          checks = 0;

    hier_path_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_digit(in_digit), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_path(out_path), .out_depth(out_depth), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic [35:0] digs;
        int          hold;
        logic [29:0] exp_path;
        logic [3:0]  exp_depth;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            check({v.name, " in_ready"}, 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_digit = v.digs[i*3 +: 3];
            in_last  = (i == v.n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({v.name, " out_valid"}, 64'(out_valid), 64'd1);
        check({v.name, " path"}, 64'(out_path), 64'(v.exp_path));
        check({v.name, " depth"}, 64'(out_depth), 64'(v.exp_depth));
        check({v.name, " err"}, 64'(out_err), 64'(v.exp_err));
        // A stalled beat offered during HOLD must not disturb the held result.
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            in_digit = 3'd1;
            in_last  = 1'b1;
            @(negedge clk);
            check({v.name, " hold in_ready"}, 64'(in_ready), 64'd0);
            check({v.name, " hold valid"}, 64'(out_valid), 64'd1);
            check({v.name, " hold path"}, 64'(out_path), 64'(v.exp_path));
            check({v.name, " hold depth"}, 64'(out_depth), 64'(v.exp_depth));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({v.name, " post valid"}, 64'(out_valid), 64'd0);
        check({v.name, " post in_ready"}, 64'(in_ready), 64'd1);
        check({v.name, " post depth"}, 64'(out_depth), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"nine", 9, 36'({3'd4, 3'd2, 21'd0}), 0,
                    30'({3'd4, 3'd2, 21'd0}), 4'd9, 1'b0};
        vecs[1] = '{"ten", 10, 36'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}), 5,
                    {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 4'd10, 1'b0};
        vecs[2] = '{"baddig", 3, 36'({3'd2, 3'd5, 3'd1}), 0,
                    30'({3'd2, 3'd5, 3'd1}), 4'd3, 1'b1};
        vecs[3] = '{"single", 1, 36'(3'd3), 0, 30'(3'd3), 4'd1, 1'b0};
        vecs[4] = '{"overflow", 12, {12{3'd1}}, 0, {10{3'd1}}, 4'd10, 1'b1};
        vecs[5] = '{"bad_last", 1, 36'(3'd7), 2, 30'(3'd7), 4'd1, 1'b1};
        rst_n = 1'b0; in_valid = 1'b0; in_digit = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst path", 64'(out_path), 64'd0);
        check("rst depth", 64'(out_depth), 64'd0);
        check("rst err", 64'(out_err), 64'd0);
        rst_n = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i]);

        // back-to-back single-digit paths with in_valid held high
        @(negedge clk);
        in_valid = 1'b1; in_digit = 3'd4; in_last = 1'b1;
        @(negedge clk);
        check("b2b first valid", 64'(out_valid), 64'd1);
        check("b2b first path", 64'(out_path), 64'd4);
        in_digit = 3'd2; out_ready = 1'b1;
        @(negedge clk);
        check("b2b gap valid", 64'(out_valid), 64'd0);
        check("b2b gap in_ready", 64'(in_ready), 64'd1);
        check("b2b gap depth", 64'(out_depth), 64'd0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("b2b second valid", 64'(out_valid), 64'd1);
        check("b2b second path", 64'(out_path), 64'd2);
        check("b2b second depth", 64'(out_depth), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b done valid", 64'(out_valid), 64'd0);

        // asynchronous reset mid-path discards the partial digits
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_digit = 3'(i + 1); in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("partial depth", 64'(out_depth), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async rst depth", 64'(out_depth), 64'd0);
        check("async rst path", 64'(out_path), 64'd0);
        check("async rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{"after_rst", 2, 36'({3'd3, 3'd2}), 0, 30'({3'd3, 3'd2}), 4'd2, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
